double_frame_buffer: RTL and testbench

Parametrised double-buffered frame store with a single clock domain. The renderer writes the back bank while the display scanout reads the front bank. A requested swap is deferred to the next frame boundary, so the display never shows a partially drawn frame. An optional hardware clear engine then fills the new back bank with a solid colour, one word per cycle. Sits between the render pipeline and the VGA scanout, and replaces the single-bank frame buffer.

---
 rtl/double_frame_buffer.sv | 159 +++++++++++++++
 tb/tb_double_frame_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/double_frame_buffer.sv
// Double-buffered frame store. The renderer writes the back bank while the
// scanout reads the front bank. Swaps wait for the next frame boundary, and
// an optional clear engine then fills the new back bank with a solid colour.
module double_frame_buffer #(
  parameter int                    WIDTH      = 160,
  parameter int                    HEIGHT     = 120,
  parameter int                    DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(12'hF00),
  parameter bit                    AUTO_CLEAR = 1'b1,
  parameter int                    ADDR_WIDTH = $clog2(WIDTH * HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] read_data,
  input  logic                  frame_start,
  input  logic                  write_en,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic                  write_ready,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  swap_done,
  input  logic                  clear_req,
  input  logic [DATA_WIDTH-1:0] clear_color,
  output logic                  clear_busy,
  output logic                  front_sel
);

  localparam int DEPTH = WIDTH * HEIGHT;
  // One extra bit so the bound itself is representable when DEPTH is a power of two.
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SWAP,
    CLEAR
  } state_e;

  state_e                  state_q,     state_d;
  logic                    front_sel_q, front_sel_d;
  logic                    swap_done_q, swap_done_d;
  logic [ADDR_WIDTH-1:0]   clr_cnt_q,   clr_cnt_d;
  logic [DATA_WIDTH-1:0]   clr_color_q, clr_color_d;
  logic [DATA_WIDTH-1:0]   read_data_q;

  logic                    mem_we;
  logic [ADDR_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    back_sel;
  logic                    read_in_range;
  logic                    write_in_range;

  // NOTE: the banks have no reset; contents come from the declaration
  // initialiser at configuration time and survive rst, like real block RAM.
  logic [DATA_WIDTH-1:0] bank_mem [2][DEPTH] = '{default: INIT_VALUE};

  assign back_sel       = ~front_sel_q;
  assign read_in_range  = {1'b0, read_addr}  < DEPTH_W;
  assign write_in_range = {1'b0, write_addr} < DEPTH_W;

  assign write_ready  = (state_q == IDLE);
  assign swap_pending = (state_q == WAIT_SWAP);
  assign clear_busy   = (state_q == CLEAR);
  assign swap_done    = swap_done_q;
  assign front_sel    = front_sel_q;
  assign read_data    = read_data_q;

  // Next-state logic: swap deferral, bank toggle and clear sequencing.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    front_sel_d = front_sel_q;
    swap_done_d = 1'b0;
    clr_cnt_d   = clr_cnt_q;
    clr_color_d = clr_color_q;
    case (state_q)
      IDLE: begin
        // A simultaneous clear request loses to the swap and is dropped.
        if (swap_req) begin
          state_d = WAIT_SWAP;
        end else if (clear_req) begin
          state_d     = CLEAR;
          clr_cnt_d   = '0;
          clr_color_d = clear_color;
        end
      end
      WAIT_SWAP: begin
        // frame_start is only looked at once we are already waiting, so a
        // boundary coinciding with the request does not trigger the swap.
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          swap_done_d = 1'b1;
          state_d     = AUTO_CLEAR ? CLEAR : IDLE;
          clr_cnt_d   = '0;
          clr_color_d = clear_color;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Back-bank write port: the clear engine owns it while active.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = write_addr;
    mem_wdata = write_data;
    if (state_q == CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_cnt_q;
      mem_wdata = clr_color_q;
    end else if (write_en && write_ready && write_in_range) begin
      mem_we = 1'b1;
    end
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      state_q     <= IDLE;
      front_sel_q <= 1'b0;
      swap_done_q <= 1'b0;
      clr_cnt_q   <= '0;
      clr_color_q <= '0;
    end else begin
      state_q     <= state_d;
      front_sel_q <= front_sel_d;
      swap_done_q <= swap_done_d;
      clr_cnt_q   <= clr_cnt_d;
      clr_color_q <= clr_color_d;
    end
  end

  // Back-bank write; deliberately not gated by rst so an aborted clear keeps its progress.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      bank_mem[back_sel][mem_waddr] <= mem_wdata;
    end
  end

  // Front-bank registered read; out-of-range addresses return zero.
  always_ff @(posedge clk) begin
    if (rst || !read_in_range) begin
      read_data_q <= '0;
    end else begin
      read_data_q <= bank_mem[front_sel_q][read_addr];
    end
  end

endmodule

// File: tb/tb_double_frame_buffer.sv
// Directed bench for double_frame_buffer: a full-size instance without
// auto-clear and a 4x2 instance with auto-clear.
module tb_double_frame_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance A: 160x120, AUTO_CLEAR=0
  logic        a_rst, a_fs, a_we, a_swap, a_clr;
  logic [14:0] a_raddr, a_waddr;
  logic [11:0] a_wdata, a_color, a_rd;
  logic        a_ready, a_pending, a_done, a_busy, a_front;

  // Instance B: 4x2, AUTO_CLEAR=1
  logic        b_rst, b_fs, b_we, b_swap, b_clr;
  logic [2:0]  b_raddr, b_waddr;
  logic [11:0] b_wdata, b_color, b_rd;
  logic        b_ready, b_pending, b_done, b_busy, b_front;

  double_frame_buffer #(
    .WIDTH(160), .HEIGHT(120), .DATA_WIDTH(12), .INIT_VALUE(12'hF00), .AUTO_CLEAR(1'b0)
  ) dut_a (
    .clk(clk), .rst(a_rst), .read_addr(a_raddr), .read_data(a_rd),
    .frame_start(a_fs), .write_en(a_we), .write_addr(a_waddr), .write_data(a_wdata),
    .write_ready(a_ready), .swap_req(a_swap), .swap_pending(a_pending),
    .swap_done(a_done), .clear_req(a_clr), .clear_color(a_color),
    .clear_busy(a_busy), .front_sel(a_front)
  );

  double_frame_buffer #(
    .WIDTH(4), .HEIGHT(2), .DATA_WIDTH(12), .INIT_VALUE(12'hF00), .AUTO_CLEAR(1'b1)
  ) dut_b (
    .clk(clk), .rst(b_rst), .read_addr(b_raddr), .read_data(b_rd),
    .frame_start(b_fs), .write_en(b_we), .write_addr(b_waddr), .write_data(b_wdata),
    .write_ready(b_ready), .swap_req(b_swap), .swap_pending(b_pending),
    .swap_done(b_done), .clear_req(b_clr), .clear_color(b_color),
    .clear_busy(b_busy), .front_sel(b_front)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int pend_cnt, done_cnt, busy_cnt, rdy_bad, guard;

  initial begin
    a_rst = 1'b1; a_fs = 1'b0; a_we = 1'b0; a_swap = 1'b0; a_clr = 1'b0;
    a_raddr = '0; a_waddr = '0; a_wdata = '0; a_color = '0;
    b_rst = 1'b1; b_fs = 1'b0; b_we = 1'b0; b_swap = 1'b0; b_clr = 1'b0;
    b_raddr = '0; b_waddr = '0; b_wdata = '0; b_color = '0;
    step();
    step();
    check("rst_read_data", 32'(a_rd), 32'h0);
    check("rst_front_sel", 32'(a_front), 32'h0);
    check("rst_write_ready", 32'(a_ready), 32'h1);
    check("rst_swap_pending", 32'(a_pending), 32'h0);
    check("rst_swap_done", 32'(a_done), 32'h0);
    check("rst_clear_busy", 32'(a_busy), 32'h0);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // ---------------- Instance A ----------------
    a_raddr = 15'd0;
    step();
    check("powerup_read0", 32'(a_rd), 32'hF00);

    // Write goes to the back bank, front still shows the init value.
    a_we = 1'b1; a_waddr = 15'd5; a_wdata = 12'h0AB; a_raddr = 15'd5;
    step();
    a_we = 1'b0;
    step();
    check("front_unchanged_addr5", 32'(a_rd), 32'hF00);

    // Out-of-range write is dropped, out-of-range read returns zero.
    a_we = 1'b1; a_waddr = 15'd19200; a_wdata = 12'hFFF; a_raddr = 15'd19200;
    step();
    a_we = 1'b0;
    check("read_oob_19200", 32'(a_rd), 32'h0);
    a_raddr = 15'h7FFF;
    step();
    check("read_oob_max", 32'(a_rd), 32'h0);

    // swap_req, three idle cycles, then frame_start.
    pend_cnt = 0; done_cnt = 0;
    a_swap = 1'b1;
    step();
    a_swap = 1'b0;
    check("write_ready_wait", 32'(a_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      pend_cnt += int'(a_pending);
      done_cnt += int'(a_done);
      step();
    end
    a_fs = 1'b1;
    pend_cnt += int'(a_pending);
    done_cnt += int'(a_done);
    step();
    a_fs = 1'b0;
    check("swap_done_with_front", 32'({a_done, a_front}), 32'h3);
    check("pending_fell", 32'(a_pending), 32'h0);
    for (int i = 0; i < 4; i++) begin
      pend_cnt += int'(a_pending);
      done_cnt += int'(a_done);
      step();
    end
    check("pending_cycles", 32'(pend_cnt), 32'd4);
    check("swap_done_pulses", 32'(done_cnt), 32'd1);
    check("front_after_swap", 32'(a_front), 32'h1);
    check("ready_no_autoclear", 32'(a_ready), 32'h1);
    check("no_clear_autoclear0", 32'(a_busy), 32'h0);

    a_raddr = 15'd5;
    step();
    check("swapped_addr5", 32'(a_rd), 32'h0AB);
    a_raddr = 15'd19199;
    step();
    check("last_word_untouched", 32'(a_rd), 32'hF00);
    a_raddr = 15'd0;
    step();
    check("addr0_untouched", 32'(a_rd), 32'hF00);

    // ---------------- Instance B ----------------
    // Swap 1: front -> 1, auto-clear bank 0 with 0x123.
    b_color = 12'h123;
    b_swap = 1'b1;
    step();
    b_swap = 1'b0;
    step();
    b_fs = 1'b1;
    step();
    b_fs = 1'b0;
    check("b_swap1_done", 32'({b_done, b_front}), 32'h3);
    b_color = 12'h999;  // must not affect the clear in progress
    busy_cnt = 0; rdy_bad = 0;
    b_waddr = 3'd3; b_wdata = 12'hBAD;
    for (int i = 0; i < 20; i++) begin
      busy_cnt += int'(b_busy);
      if (b_busy && b_ready) rdy_bad++;
      b_we = b_busy;
      step();
    end
    b_we = 1'b0;
    check("b_clear_busy_cycles", 32'(busy_cnt), 32'd8);
    check("b_ready_low_in_clear", 32'(rdy_bad), 32'd0);

    // Swap 2: front -> 0, bank 0 must read 0x123 everywhere; bank 1 auto-clears with 0x456.
    b_color = 12'h456;
    b_swap = 1'b1;
    step();
    b_swap = 1'b0;
    step();
    b_fs = 1'b1;
    step();
    b_fs = 1'b0;
    check("b_swap2_front", 32'(b_front), 32'h0);
    for (int i = 0; i < 8; i++) begin
      b_raddr = 3'(i);
      step();
      check($sformatf("b_cleared_123_%0d", i), 32'(b_rd), 32'h123);
    end
    guard = 0;
    while (b_busy && guard < 20) begin
      step();
      guard++;
    end
    check("b_clear2_drained", 32'(b_busy), 32'h0);

    // Coincident swap_req and frame_start: no swap until the next boundary.
    b_swap = 1'b1; b_fs = 1'b1;
    step();
    b_swap = 1'b0; b_fs = 1'b0;
    check("b_coincident_front", 32'(b_front), 32'h0);
    check("b_coincident_pending", 32'(b_pending), 32'h1);
    check("b_coincident_no_done", 32'(b_done), 32'h0);
    step();
    step();
    b_fs = 1'b1;
    step();
    b_fs = 1'b0;
    check("b_swap3_done", 32'({b_done, b_front}), 32'h3);
    for (int i = 0; i < 8; i++) begin
      b_raddr = 3'(i);
      step();
      check($sformatf("b_bank1_456_%0d", i), 32'(b_rd), 32'h456);
    end
    guard = 0;
    while (b_busy && guard < 20) begin
      step();
      guard++;
    end
    check("b_clear3_drained", 32'(b_busy), 32'h0);

    // Manual clear of bank 0 with 0x789, reset on the 3rd clear cycle.
    b_color = 12'h789;
    b_clr = 1'b1;
    step();
    b_clr = 1'b0;
    b_color = 12'h000;
    check("b_manual_clear_busy", 32'(b_busy), 32'h1);
    step();
    step();
    b_rst = 1'b1;
    step();
    b_rst = 1'b0;
    check("b_rst_busy", 32'(b_busy), 32'h0);
    check("b_rst_ready", 32'(b_ready), 32'h1);
    check("b_rst_front", 32'(b_front), 32'h0);
    check("b_rst_pending", 32'(b_pending), 32'h0);
    check("b_rst_read_data", 32'(b_rd), 32'h0);
    for (int i = 0; i < 8; i++) begin
      b_raddr = 3'(i);
      step();
      check($sformatf("b_partial_%0d", i), 32'(b_rd), (i < 3) ? 32'h789 : 32'h456);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
